// File: rtl/i2c_target_if.sv
// I2C pin and host register-port bundle for i2c_target.
// The target uses the slave view; the bus initiator and host use master.
interface i2c_target_if;
    logic        scl_in;
    logic        sda_in;
    logic        sda_oe;
    logic [3:0]  host_addr;
    logic [7:0]  host_wdata;
    logic        host_write;
    logic [7:0]  host_rdata;
    logic        bus_wr_pulse;
    logic [15:0] status;

    modport slave (
        input  scl_in, sda_in,
        input  host_addr, host_wdata, host_write,
        output sda_oe, host_rdata, bus_wr_pulse, status
    );

    modport master (
        output scl_in, sda_in,
        output host_addr, host_wdata, host_write,
        input  sda_oe, host_rdata, bus_wr_pulse, status
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target with a 16 x 8-bit register file, pointer-based bus access
// with auto-increment, and a combinational host read / strobed write port.
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h48
) (
    input logic         clk,
    input logic         rst_n,
    i2c_target_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        WAIT
    } state_t;

    state_t     state, state_n;
    logic [1:0] scl_q, sda_q;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall;
    logic       start_det, stop_det;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sr, sr_n;
    logic [3:0] ptr, ptr_n;
    logic       rw, rw_n;
    logic       oe, oe_n;
    logic       nack, nack_n;
    logic       commit;
    logic [7:0] rx_byte;
    logic [7:0] wcount;
    logic       wr_pulse;
    logic [7:0] regs [16];

    // Synchronizers idle high so reset does not fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 2'b11;
            sda_q <= 2'b11;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= {scl_q[0], bus.scl_in};
            sda_q <= {sda_q[0], bus.sda_in};
            scl_d <= scl_q[1];
            sda_d <= sda_q[1];
        end
    end

    assign scl_s     = scl_q[1];
    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {sr[6:0], sda_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            ptr   <= '0;
            rw    <= 1'b0;
            oe    <= 1'b0;
            nack  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
            ptr   <= ptr_n;
            rw    <= rw_n;
            oe    <= oe_n;
            nack  <= nack_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        ptr_n   = ptr;
        rw_n    = rw;
        oe_n    = oe;
        nack_n  = nack;
        commit  = 1'b0;
        if (start_det) begin
            state_n = ADDR;
            cnt_n   = '0;
            nack_n  = 1'b0;
        end else if (stop_det) begin
            state_n = IDLE;
            cnt_n   = '0;
            oe_n    = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                end
                ADDR: begin
                    if (scl_rise) begin
                        sr_n  = rx_byte;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n   = '0;
                            rw_n    = sda_s;
                            state_n = (sr[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        sr_n  = rx_byte;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n   = '0;
                            ptr_n   = rx_byte[3:0];
                            state_n = PTR_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        sr_n  = rx_byte;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n   = '0;
                            commit  = 1'b1;
                            ptr_n   = ptr + 4'd1;
                            state_n = WDATA_ACK;
                        end
                    end
                end
                // cnt marks whether the ACK low is already being driven.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            oe_n  = 1'b1;
                            cnt_n = 4'd1;
                        end else begin
                            cnt_n = '0;
                            oe_n  = 1'b0;
                            if (state != ADDR_ACK) begin
                                state_n = WDATA;
                            end else if (rw) begin
                                state_n = RDATA;
                                sr_n    = regs[ptr];
                                oe_n    = ~regs[ptr][7];
                            end else begin
                                state_n = PTR;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n   = '0;
                            state_n = RDATA_ACK;
                        end
                    end else if (scl_fall) begin
                        sr_n = sr << 1;
                        oe_n = ~sr[6];
                    end
                end
                // cnt = 1 means the initiator ACKed and a reload is due.
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ptr_n = ptr + 4'd1;
                        if (sda_s) begin
                            nack_n  = 1'b1;
                            state_n = WAIT;
                        end else begin
                            cnt_n = 4'd1;
                        end
                    end else if (scl_fall) begin
                        if (cnt == 4'd1) begin
                            cnt_n   = '0;
                            state_n = RDATA;
                            sr_n    = regs[ptr];
                            oe_n    = ~regs[ptr][7];
                        end else begin
                            oe_n = 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (scl_fall) oe_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

    // A bus commit to the same register overrides the host strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            if (bus.host_write && !(commit && bus.host_addr == ptr))
                regs[bus.host_addr] <= bus.host_wdata;
            if (commit)
                regs[ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_pulse <= 1'b0;
            wcount   <= '0;
        end else begin
            wr_pulse <= commit;
            if (commit) wcount <= wcount + 8'd1;
        end
    end

    assign bus.sda_oe       = oe;
    assign bus.host_rdata   = regs[bus.host_addr];
    assign bus.bus_wr_pulse = wr_pulse;
    assign bus.status       = {ptr, 2'b00, nack, state != IDLE, wcount};
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: transaction-level register model and scoreboard
// queues checked by monitors, with directed cases plus a randomized mix.
module tb_i2c_target;
    localparam int Q = 5;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic tb_scl = 1'b1;
    logic tb_sda = 1'b1;

    i2c_target_if bus();

    assign bus.scl_in = tb_scl;
    assign bus.sda_in = tb_sda & ~bus.sda_oe;

    i2c_target #(.DEV_ADDR(7'h48)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [3:0] ptr;
        logic [7:0] cnt;
    } wr_exp_t;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int oe_viol = 0;
    logic oe_guard = 1'b0;

    logic [7:0] m_regs [16];
    logic [3:0] m_ptr;
    logic [7:0] m_cnt;
    logic       m_nack;
    logic [7:0] wbuf [8];

    wr_exp_t    wr_q [$];
    logic [7:0] rd_q [$];
    logic [7:0] rd_obs;
    event       rd_ev;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr  = 4'd0;
        m_cnt  = 8'd0;
        m_nack = 1'b0;
    endtask

    task automatic model_commit(logic [7:0] d);
        wr_exp_t e;
        m_regs[m_ptr] = d;
        m_ptr = m_ptr + 4'd1;
        m_cnt = m_cnt + 8'd1;
        e.ptr = m_ptr;
        e.cnt = m_cnt;
        wr_q.push_back(e);
    endtask

    always @(negedge clk) begin
        wr_exp_t e;
        if (rst_n && bus.bus_wr_pulse === 1'b1) begin
            pulses++;
            if (wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wr_pulse: got unexpected pulse, required none");
            end else begin
                e = wr_q.pop_front();
                check("wr_ptr", bus.status[15:12], e.ptr);
                check("wr_cnt", bus.status[7:0], e.cnt);
            end
        end
    end

    always @(rd_ev) begin
        if (rd_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rd_byte: got %0h, required no byte", rd_obs);
        end else begin
            check("rd_byte", rd_obs, rd_q.pop_front());
        end
    end

    always @(negedge clk)
        if (oe_guard && bus.sda_oe) oe_viol++;

    task automatic host_wr(logic [3:0] a, logic [7:0] d);
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.host_write = 1'b1;
        cyc(1);
        bus.host_write = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic check_regs(string tag);
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            bus.host_addr = 4'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), bus.host_rdata, m_regs[i]);
        end
    endtask

    task automatic check_status(string tag);
        check(tag, bus.status, {m_ptr, 2'b00, m_nack, 1'b0, m_cnt});
    endtask

    task automatic i2c_start();
        tb_sda = 1'b1;
        cyc(Q);
        tb_scl = 1'b1;
        cyc(Q);
        tb_sda = 1'b0;
        cyc(Q);
        tb_scl = 1'b0;
        cyc(Q);
        m_nack = 1'b0;
    endtask

    task automatic i2c_stop();
        tb_sda = 1'b0;
        cyc(Q);
        tb_scl = 1'b1;
        cyc(Q);
        tb_sda = 1'b1;
        cyc(2 * Q);
    endtask

    task automatic send_bit(logic b);
        tb_sda = b;
        cyc(Q);
        tb_scl = 1'b1;
        cyc(2 * Q);
        tb_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic recv_bit(output logic b);
        tb_sda = 1'b1;
        cyc(Q);
        tb_scl = 1'b1;
        cyc(Q);
        b = bus.sda_in;
        cyc(Q);
        tb_scl = 1'b0;
        cyc(Q);
    endtask

    task automatic send_byte(logic [7:0] d, logic exp_ack, string nm);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        check(nm, a, exp_ack);
    endtask

    task automatic recv_byte(logic nack_bit);
        logic [7:0] b;
        for (int i = 7; i >= 0; i--) recv_bit(b[i]);
        rd_obs = b;
        ->rd_ev;
        send_bit(nack_bit);
    endtask

    // Last bit is issued by hand so the host strobe lands on the commit cycle.
    task automatic send_byte_coll(logic [7:0] d, logic [3:0] ha, logic [7:0] hd);
        logic a;
        for (int i = 7; i >= 1; i--) send_bit(d[i]);
        if (ha != m_ptr) m_regs[ha] = hd;
        model_commit(d);
        tb_sda = d[0];
        cyc(Q);
        tb_scl = 1'b1;
        cyc(2);
        bus.host_addr  = ha;
        bus.host_wdata = hd;
        bus.host_write = 1'b1;
        cyc(1);
        check("coll_align", bus.bus_wr_pulse, 1'b1);
        bus.host_write = 1'b0;
        cyc(2 * Q - 3);
        tb_scl = 1'b0;
        cyc(Q);
        recv_bit(a);
        check("coll_ack", a, 1'b0);
    endtask

    task automatic bus_write(logic [7:0] p, int n);
        i2c_start();
        send_byte(8'h90, 1'b0, "wr_addr_ack");
        send_byte(p, 1'b0, "wr_ptr_ack");
        m_ptr = p[3:0];
        for (int k = 0; k < n; k++) begin
            model_commit(wbuf[k]);
            send_byte(wbuf[k], 1'b0, "wr_data_ack");
        end
        i2c_stop();
    endtask

    task automatic bus_read(logic [7:0] p, int n);
        i2c_start();
        send_byte(8'h90, 1'b0, "rd_waddr_ack");
        send_byte(p, 1'b0, "rd_ptr_ack");
        m_ptr = p[3:0];
        i2c_start();
        send_byte(8'h91, 1'b0, "rd_raddr_ack");
        for (int k = 0; k < n; k++) begin
            rd_q.push_back(m_regs[m_ptr]);
            m_ptr = m_ptr + 4'd1;
            recv_byte(k == n - 1);
        end
        m_nack = 1'b1;
        i2c_stop();
    endtask

    initial begin
        cyc(90000);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p;
        int n;
        bus.host_addr  = 4'd0;
        bus.host_wdata = 8'h00;
        bus.host_write = 1'b0;
        model_reset();

        cyc(3);
        check("rst_status", bus.status, 16'h0000);
        check("rst_oe", bus.sda_oe, 1'b0);
        check("rst_pulse", bus.bus_wr_pulse, 1'b0);
        rst_n = 1'b1;
        cyc(5);
        check_regs("rst");

        wbuf[0] = 8'hA5;
        wbuf[1] = 8'h5A;
        bus_write(8'h03, 2);
        check_status("write_status");
        check("write_pulses", pulses, 2);
        check_regs("write");

        host_wr(4'd14, 8'h11);
        host_wr(4'd15, 8'h22);
        host_wr(4'd0, 8'h33);
        bus_read(8'h0E, 3);
        check_status("burst_status");
        check("burst_ptr", bus.status[15:12], 4'd1);

        oe_viol  = 0;
        oe_guard = 1'b1;
        i2c_start();
        send_byte(8'h92, 1'b1, "mis_addr_nack");
        send_byte(8'h03, 1'b1, "mis_b1_nack");
        send_byte(8'h77, 1'b1, "mis_b2_nack");
        check("mis_busy", bus.status[8], 1'b1);
        i2c_stop();
        oe_guard = 1'b0;
        check("mis_oe", oe_viol, 0);
        check_status("mis_status");
        check_regs("mis");

        i2c_start();
        send_byte(8'h90, 1'b0, "smb_addr_ack");
        send_byte(8'h07, 1'b0, "smb_ptr_ack");
        m_ptr = 4'd7;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        i2c_stop();
        check("smb_oe", bus.sda_oe, 1'b0);
        check_status("smb_status");
        check_regs("smb");

        i2c_start();
        send_byte(8'h90, 1'b0, "col_addr_ack");
        send_byte(8'h05, 1'b0, "col_ptr_ack");
        m_ptr = 4'd5;
        send_byte_coll(8'h12, 4'd5, 8'hFF);
        send_byte_coll(8'h34, 4'd9, 8'hC3);
        i2c_stop();
        bus.host_addr = 4'd5;
        #1;
        check("coll_reg5", bus.host_rdata, 8'h12);
        check_status("coll_status");
        check_regs("coll");

        host_wr(4'd8, 8'h3C);
        i2c_start();
        send_byte(8'h90, 1'b0, "rst_waddr_ack");
        send_byte(8'h08, 1'b0, "rst_ptr_ack");
        m_ptr = 4'd8;
        i2c_start();
        send_byte(8'h91, 1'b0, "rst_raddr_ack");
        check("rst_drive", bus.sda_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_release", bus.sda_oe, 1'b0);
        model_reset();
        cyc(3);
        check_status("rst_mid_status");
        rst_n = 1'b1;
        tb_sda = 1'b1;
        cyc(Q);
        check_regs("rst_mid");
        wbuf[0] = 8'h6E;
        bus_write(8'h0A, 1);
        bus_read(8'h0A, 1);
        check_status("post_rst_status");

        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 2))
                0: host_wr(4'($urandom_range(0, 15)), 8'($urandom));
                1: begin
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                    p = 8'($urandom);
                    bus_write(p, n);
                end
                default: begin
                    n = $urandom_range(1, 4);
                    p = 8'($urandom);
                    bus_read(p, n);
                end
            endcase
            check_status($sformatf("rnd%0d_status", it));
            check_regs($sformatf("rnd%0d", it));
        end

        cyc(4);
        check("sb_drain", wr_q.size() + rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
